// File: rtl/vend_pkg.sv
// Shared types for the vending transaction controller: FSM states, coin codes
// and the coin-code to 5-cent-unit conversion.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    function automatic logic [1:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return 2'd1;
            COIN_10: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_ctrl.sv
// Vending transaction controller: credit accumulation, vend, change and refund.
// Optional inactivity refund in CREDIT is enabled by defining VEND_TIMEOUT_EN.
module vend_ctrl #(
    parameter int PRICE       = 3,
    parameter int MAX_CREDIT  = 6,
    parameter int TIMEOUT_CYC = 1000,
    parameter int CW          = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    coin,
    input  logic          sel,
    input  logic          cancel,
    input  logic          disp_ack,
    input  logic          chg_ack,
    output logic          disp_req,
    output logic          chg_req,
    output logic          coin_reject,
    output logic [CW-1:0] credit,
    output logic          busy
);
    import vend_pkg::*;

    localparam logic [CW-1:0] PRICE_U = CW'(PRICE);
    localparam logic [CW-1:0] MAX_U   = CW'(MAX_CREDIT);

    state_t        state_reg;
    logic [CW-1:0] credit_reg;
    logic          disp_req_reg;
    logic          chg_req_reg;
    logic          coin_reject_reg;
    logic          busy_reg;

    logic [CW-1:0] coin_sum;
    logic          coin_ok;
    logic          coin_seen;

    // CW holds MAX_CREDIT + 2, so the trial sum cannot wrap before the ceiling test.
    assign coin_sum  = credit_reg + CW'(coin_value(coin));
    assign coin_ok   = ((coin == COIN_5) || (coin == COIN_10)) && (coin_sum <= MAX_U);
    assign coin_seen = (coin != COIN_NONE);

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] timer_reg;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            credit_reg      <= '0;
            disp_req_reg    <= 1'b0;
            chg_req_reg     <= 1'b0;
            coin_reject_reg <= 1'b0;
            busy_reg        <= 1'b0;
`ifdef VEND_TIMEOUT_EN
            timer_reg       <= '0;
`endif
        end else begin
            coin_reject_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (coin_ok) begin
                        credit_reg <= coin_sum;
                        state_reg  <= CREDIT;
                    end else if (coin_seen) begin
                        coin_reject_reg <= 1'b1;
                    end
`ifdef VEND_TIMEOUT_EN
                    timer_reg <= '0;
`endif
                end
                CREDIT: begin
                    // Priority: cancel, then coin, then sel (then timeout).
                    if (cancel) begin
                        coin_reject_reg <= coin_seen;
                        state_reg       <= CHANGE;
                        chg_req_reg     <= 1'b1;
                        busy_reg        <= 1'b1;
                    end else if (coin_seen) begin
                        if (coin_ok) begin
                            credit_reg <= coin_sum;
                        end else begin
                            coin_reject_reg <= 1'b1;
                        end
`ifdef VEND_TIMEOUT_EN
                        if (coin_ok) begin
                            timer_reg <= '0;
                        end else if (timer_reg < T_LAST) begin
                            timer_reg <= timer_reg + 1'b1;
                        end
`endif
                    end else if (sel && (credit_reg >= PRICE_U)) begin
                        credit_reg   <= credit_reg - PRICE_U;
                        state_reg    <= DISPENSE;
                        disp_req_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
`ifdef VEND_TIMEOUT_EN
                    else if (timer_reg >= T_LAST) begin
                        state_reg   <= CHANGE;
                        chg_req_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
`endif
                end
                DISPENSE: begin
                    coin_reject_reg <= coin_seen;
                    if (disp_ack) begin
                        disp_req_reg <= 1'b0;
                        if (credit_reg != '0) begin
                            state_reg   <= CHANGE;
                            chg_req_reg <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                CHANGE: begin
                    coin_reject_reg <= coin_seen;
                    if (chg_ack) begin
                        credit_reg <= credit_reg - 1'b1;
                        if (credit_reg == CW'(1)) begin
                            state_reg   <= IDLE;
                            chg_req_reg <= 1'b0;
                            busy_reg    <= 1'b0;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign disp_req    = disp_req_reg;
    assign chg_req     = chg_req_reg;
    assign coin_reject = coin_reject_reg;
    assign credit      = credit_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: each step queues its expected outputs when the
// stimulus is driven and the owning test pops and compares them after the edge.
module tb_vend_ctrl;

    localparam int C0  = 0;
    localparam int C5  = 1;
    localparam int C10 = 2;
    localparam int CB  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] coin = 2'b00;
    logic       sel = 1'b0;
    logic       cancel = 1'b0;
    logic       disp_ack = 1'b0;
    logic       chg_ack = 1'b0;
    logic       disp_req;
    logic       chg_req;
    logic       coin_reject;
    logic [3:0] credit;
    logic       busy;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic       rst;
        logic [1:0] coin;
        logic       sel;
        logic       cancel;
        logic       dack;
        logic       cack;
        logic [3:0] credit;
        logic       dreq;
        logic       creq;
        logic       rej;
        logic       busy;
    } vec_t;

    typedef struct {
        logic [3:0] credit;
        logic       dreq;
        logic       creq;
        logic       rej;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    vend_ctrl #(
        .PRICE(3),
        .MAX_CREDIT(6),
        .TIMEOUT_CYC(10),
        .CW(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .coin(coin),
        .sel(sel),
        .cancel(cancel),
        .disp_ack(disp_ack),
        .chg_ack(chg_ack),
        .disp_req(disp_req),
        .chg_req(chg_req),
        .coin_reject(coin_reject),
        .credit(credit),
        .busy(busy)
    );

    function automatic vec_t mk(input int r, input int c, input int s, input int x,
                                input int da, input int ca, input int cr,
                                input int dq, input int cq, input int rj, input int bz);
        vec_t v;
        v.rst = 1'(r);   v.coin = 2'(c);  v.sel = 1'(s);   v.cancel = 1'(x);
        v.dack = 1'(da); v.cack = 1'(ca); v.credit = 4'(cr);
        v.dreq = 1'(dq); v.creq = 1'(cq); v.rej = 1'(rj);  v.busy = 1'(bz);
        return v;
    endfunction

    // Drives one cycle of stimulus, queues its expectation, and returns #1 after the edge.
    task automatic drive_step(input vec_t v);
        exp_t e;
        rst = v.rst; coin = v.coin; sel = v.sel; cancel = v.cancel;
        disp_ack = v.dack; chg_ack = v.cack;
        e.credit = v.credit; e.dreq = v.dreq; e.creq = v.creq; e.rej = v.rej; e.busy = v.busy;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0; coin = 2'b00; sel = 1'b0; cancel = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0;
    endtask

    task automatic test_reset();
        vec_t v[$];
        exp_t e;
        v.push_back(mk(1, C10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(1, C0,  1, 0, 1, 1, 0, 0, 0, 0, 0));
        foreach (v[i]) begin
            drive_step(v[i]);
            e = exp_q.pop_front();
            checks++;
            if ({credit, disp_req, chg_req, coin_reject, busy} !== {e.credit, e.dreq, e.creq, e.rej, e.busy})
                $display("FAIL reset step %0d: got cr=%0d dq=%b cq=%b rj=%b bz=%b want cr=%0d dq=%b cq=%b rj=%b bz=%b",
                         i, credit, disp_req, chg_req, coin_reject, busy, e.credit, e.dreq, e.creq, e.rej, e.busy);
            else begin
                passes++;
                $display("reset step %0d: cr=%0d dq=%b cq=%b rj=%b bz=%b ok", i, credit, disp_req, chg_req, coin_reject, busy);
            end
        end
    endtask

    task automatic test_vend_exact();
        vec_t v[$];
        exp_t e;
        v.push_back(mk(0, C5,  0, 0, 0, 0, 1, 0, 0, 0, 0));
        v.push_back(mk(0, C10, 0, 0, 0, 0, 3, 0, 0, 0, 0));
        v.push_back(mk(0, C0,  1, 0, 0, 0, 0, 1, 0, 0, 1));
        v.push_back(mk(0, C0,  0, 0, 0, 0, 0, 1, 0, 0, 1));
        v.push_back(mk(0, C0,  0, 0, 0, 0, 0, 1, 0, 0, 1));
        v.push_back(mk(0, C0,  0, 0, 1, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(0, C0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (v[i]) begin
            drive_step(v[i]);
            e = exp_q.pop_front();
            checks++;
            if ({credit, disp_req, chg_req, coin_reject, busy} !== {e.credit, e.dreq, e.creq, e.rej, e.busy})
                $display("FAIL vend_exact step %0d: got cr=%0d dq=%b cq=%b rj=%b bz=%b want cr=%0d dq=%b cq=%b rj=%b bz=%b",
                         i, credit, disp_req, chg_req, coin_reject, busy, e.credit, e.dreq, e.creq, e.rej, e.busy);
            else begin
                passes++;
                $display("vend_exact step %0d: cr=%0d dq=%b cq=%b rj=%b bz=%b ok", i, credit, disp_req, chg_req, coin_reject, busy);
            end
        end
    endtask

    task automatic test_vend_change();
        vec_t v[$];
        exp_t e;
        v.push_back(mk(0, C10, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        v.push_back(mk(0, C10, 0, 0, 0, 0, 4, 0, 0, 0, 0));
        v.push_back(mk(0, C0,  1, 0, 0, 0, 1, 1, 0, 0, 1));
        v.push_back(mk(0, C5,  0, 0, 0, 1, 1, 1, 0, 1, 1));  // coin in DISPENSE rejected, stray chg_ack ignored
        v.push_back(mk(0, C0,  0, 0, 1, 0, 1, 0, 1, 0, 1));
        v.push_back(mk(0, C0,  0, 0, 0, 0, 1, 0, 1, 0, 1));
        v.push_back(mk(0, C0,  0, 0, 0, 1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, C0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (v[i]) begin
            drive_step(v[i]);
            e = exp_q.pop_front();
            checks++;
            if ({credit, disp_req, chg_req, coin_reject, busy} !== {e.credit, e.dreq, e.creq, e.rej, e.busy})
                $display("FAIL vend_change step %0d: got cr=%0d dq=%b cq=%b rj=%b bz=%b want cr=%0d dq=%b cq=%b rj=%b bz=%b",
                         i, credit, disp_req, chg_req, coin_reject, busy, e.credit, e.dreq, e.creq, e.rej, e.busy);
            else begin
                passes++;
                $display("vend_change step %0d: cr=%0d dq=%b cq=%b rj=%b bz=%b ok", i, credit, disp_req, chg_req, coin_reject, busy);
            end
        end
    endtask

    task automatic test_reject();
        vec_t v[$];
        exp_t e;
        v.push_back(mk(0, C10, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        v.push_back(mk(0, C10, 0, 0, 0, 0, 4, 0, 0, 0, 0));
        v.push_back(mk(0, C10, 0, 0, 0, 0, 6, 0, 0, 0, 0));
        v.push_back(mk(0, C5,  0, 0, 0, 0, 6, 0, 0, 1, 0));
        v.push_back(mk(0, C0,  0, 0, 0, 0, 6, 0, 0, 0, 0));
        v.push_back(mk(0, CB,  0, 0, 0, 0, 6, 0, 0, 1, 0));
        v.push_back(mk(0, C0,  1, 0, 0, 0, 3, 1, 0, 0, 1));
        v.push_back(mk(0, C0,  0, 0, 1, 0, 3, 0, 1, 0, 1));
        v.push_back(mk(0, C0,  0, 0, 0, 1, 2, 0, 1, 0, 1));
        v.push_back(mk(0, C0,  0, 0, 0, 1, 1, 0, 1, 0, 1));
        v.push_back(mk(0, C0,  0, 0, 0, 1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, CB,  0, 0, 0, 0, 0, 0, 0, 1, 0));
        v.push_back(mk(0, C0,  1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (v[i]) begin
            drive_step(v[i]);
            e = exp_q.pop_front();
            checks++;
            if ({credit, disp_req, chg_req, coin_reject, busy} !== {e.credit, e.dreq, e.creq, e.rej, e.busy})
                $display("FAIL reject step %0d: got cr=%0d dq=%b cq=%b rj=%b bz=%b want cr=%0d dq=%b cq=%b rj=%b bz=%b",
                         i, credit, disp_req, chg_req, coin_reject, busy, e.credit, e.dreq, e.creq, e.rej, e.busy);
            else begin
                passes++;
                $display("reject step %0d: cr=%0d dq=%b cq=%b rj=%b bz=%b ok", i, credit, disp_req, chg_req, coin_reject, busy);
            end
        end
    endtask

    task automatic test_cancel();
        vec_t v[$];
        exp_t e;
        v.push_back(mk(0, C10, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        v.push_back(mk(0, C0,  0, 1, 0, 0, 2, 0, 1, 0, 1));
        v.push_back(mk(0, C5,  0, 0, 0, 0, 2, 0, 1, 1, 1));
        v.push_back(mk(0, C0,  1, 0, 0, 1, 1, 0, 1, 0, 1));
        v.push_back(mk(0, C0,  0, 0, 0, 1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, C5,  0, 0, 0, 0, 1, 0, 0, 0, 0));
        v.push_back(mk(0, C10, 1, 1, 0, 0, 1, 0, 1, 1, 1));  // cancel beats coin and sel
        v.push_back(mk(0, C0,  0, 0, 0, 1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, C0,  0, 0, 1, 1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, C0,  0, 1, 0, 0, 0, 0, 0, 0, 0));
        foreach (v[i]) begin
            drive_step(v[i]);
            e = exp_q.pop_front();
            checks++;
            if ({credit, disp_req, chg_req, coin_reject, busy} !== {e.credit, e.dreq, e.creq, e.rej, e.busy})
                $display("FAIL cancel step %0d: got cr=%0d dq=%b cq=%b rj=%b bz=%b want cr=%0d dq=%b cq=%b rj=%b bz=%b",
                         i, credit, disp_req, chg_req, coin_reject, busy, e.credit, e.dreq, e.creq, e.rej, e.busy);
            else begin
                passes++;
                $display("cancel step %0d: cr=%0d dq=%b cq=%b rj=%b bz=%b ok", i, credit, disp_req, chg_req, coin_reject, busy);
            end
        end
    endtask

    task automatic test_priority();
        vec_t v[$];
        exp_t e;
        v.push_back(mk(0, C5,  0, 0, 0, 0, 1, 0, 0, 0, 0));
        v.push_back(mk(0, C0,  1, 0, 0, 0, 1, 0, 0, 0, 0));
        v.push_back(mk(0, C10, 1, 0, 0, 0, 3, 0, 0, 0, 0));
        v.push_back(mk(0, C0,  1, 0, 0, 0, 0, 1, 0, 0, 1));
        v.push_back(mk(0, C0,  1, 1, 0, 0, 0, 1, 0, 0, 1));
        v.push_back(mk(0, C0,  0, 0, 1, 0, 0, 0, 0, 0, 0));
        foreach (v[i]) begin
            drive_step(v[i]);
            e = exp_q.pop_front();
            checks++;
            if ({credit, disp_req, chg_req, coin_reject, busy} !== {e.credit, e.dreq, e.creq, e.rej, e.busy})
                $display("FAIL priority step %0d: got cr=%0d dq=%b cq=%b rj=%b bz=%b want cr=%0d dq=%b cq=%b rj=%b bz=%b",
                         i, credit, disp_req, chg_req, coin_reject, busy, e.credit, e.dreq, e.creq, e.rej, e.busy);
            else begin
                passes++;
                $display("priority step %0d: cr=%0d dq=%b cq=%b rj=%b bz=%b ok", i, credit, disp_req, chg_req, coin_reject, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        exp_t e;
        v.push_back(mk(0, C10, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        v.push_back(mk(0, C5,  0, 0, 0, 0, 3, 0, 0, 0, 0));
        v.push_back(mk(0, C0,  1, 0, 0, 0, 0, 1, 0, 0, 1));
        v.push_back(mk(0, C0,  0, 0, 1, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(0, C10, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        v.push_back(mk(0, C10, 0, 0, 0, 0, 4, 0, 0, 0, 0));
        v.push_back(mk(0, C0,  1, 0, 0, 0, 1, 1, 0, 0, 1));
        v.push_back(mk(0, C0,  0, 0, 1, 0, 1, 0, 1, 0, 1));
        v.push_back(mk(0, C0,  0, 0, 0, 1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, C5,  0, 0, 0, 0, 1, 0, 0, 0, 0));
        v.push_back(mk(0, C0,  0, 1, 0, 0, 1, 0, 1, 0, 1));
        v.push_back(mk(0, C0,  0, 0, 0, 1, 0, 0, 0, 0, 0));
        foreach (v[i]) begin
            drive_step(v[i]);
            e = exp_q.pop_front();
            checks++;
            if ({credit, disp_req, chg_req, coin_reject, busy} !== {e.credit, e.dreq, e.creq, e.rej, e.busy})
                $display("FAIL back_to_back step %0d: got cr=%0d dq=%b cq=%b rj=%b bz=%b want cr=%0d dq=%b cq=%b rj=%b bz=%b",
                         i, credit, disp_req, chg_req, coin_reject, busy, e.credit, e.dreq, e.creq, e.rej, e.busy);
            else begin
                passes++;
                $display("back_to_back step %0d: cr=%0d dq=%b cq=%b rj=%b bz=%b ok", i, credit, disp_req, chg_req, coin_reject, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        vec_t v[$];
        exp_t e;
        v.push_back(mk(0, C10, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        v.push_back(mk(0, C10, 0, 0, 0, 0, 4, 0, 0, 0, 0));
        v.push_back(mk(0, C10, 0, 0, 0, 0, 6, 0, 0, 0, 0));
        v.push_back(mk(0, C0,  1, 0, 0, 0, 3, 1, 0, 0, 1));
        v.push_back(mk(1, C0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(0, C0,  0, 0, 1, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(0, C0,  0, 0, 0, 1, 0, 0, 0, 0, 0));
        foreach (v[i]) begin
            drive_step(v[i]);
            e = exp_q.pop_front();
            checks++;
            if ({credit, disp_req, chg_req, coin_reject, busy} !== {e.credit, e.dreq, e.creq, e.rej, e.busy})
                $display("FAIL reset_mid step %0d: got cr=%0d dq=%b cq=%b rj=%b bz=%b want cr=%0d dq=%b cq=%b rj=%b bz=%b",
                         i, credit, disp_req, chg_req, coin_reject, busy, e.credit, e.dreq, e.creq, e.rej, e.busy);
            else begin
                passes++;
                $display("reset_mid step %0d: cr=%0d dq=%b cq=%b rj=%b bz=%b ok", i, credit, disp_req, chg_req, coin_reject, busy);
            end
        end
    endtask

`ifdef VEND_TIMEOUT_EN
    task automatic test_timeout();
        vec_t v[$];
        exp_t e;
        // Plain timeout: CHANGE entered on the 10th edge after the coin edge.
        v.push_back(mk(0, C5, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int k = 1; k <= 9; k++) v.push_back(mk(0, C0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        v.push_back(mk(0, C0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
        v.push_back(mk(0, C0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // A coin on edge 8 restarts the count, so CHANGE lands on edge 18.
        v.push_back(mk(0, C5, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int k = 1; k <= 7; k++) v.push_back(mk(0, C0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        v.push_back(mk(0, C5, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        for (int k = 9; k <= 17; k++) v.push_back(mk(0, C0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        v.push_back(mk(0, C0, 0, 0, 0, 0, 2, 0, 1, 0, 1));
        v.push_back(mk(0, C0, 0, 0, 0, 1, 1, 0, 1, 0, 1));
        v.push_back(mk(0, C0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        foreach (v[i]) begin
            drive_step(v[i]);
            e = exp_q.pop_front();
            checks++;
            if ({credit, disp_req, chg_req, coin_reject, busy} !== {e.credit, e.dreq, e.creq, e.rej, e.busy})
                $display("FAIL timeout step %0d: got cr=%0d dq=%b cq=%b rj=%b bz=%b want cr=%0d dq=%b cq=%b rj=%b bz=%b",
                         i, credit, disp_req, chg_req, coin_reject, busy, e.credit, e.dreq, e.creq, e.rej, e.busy);
            else begin
                passes++;
                $display("timeout step %0d: cr=%0d dq=%b cq=%b rj=%b bz=%b ok", i, credit, disp_req, chg_req, coin_reject, busy);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_vend_exact();
        test_vend_change();
        test_reject();
        test_cancel();
        test_priority();
        test_back_to_back();
        test_reset_mid();
`ifdef VEND_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Transaction controller for the vending machine. It accepts coins, accumulates credit, and starts a vend when the customer selects and credit covers the price. It then sequences the dispense mechanism and the change/refund payout through req/ack handshakes. It sits between the coin acceptor front end and the dispense and change actuators, replacing the bare state-per-coin FSM with credit arithmetic, rejection and refund.

## Interface
- PRICE, 3: item price in 5-cent units (3 = 15c).
- MAX_CREDIT, 6: credit ceiling in 5-cent units.
- TIMEOUT_CYC, 1000: inactivity limit in cycles; used only with VEND_TIMEOUT_EN.
- CW, 4: credit width; must hold MAX_CREDIT + 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- coin  in  2  one-cycle coin code: 00 none, 01 = 5c (1 unit), 10 = 10c (2 units), 11 invalid.
- sel  in  1  one-cycle vend request.
- cancel  in  1  one-cycle refund request.
- disp_ack  in  1  dispenser done.
- chg_ack  in  1  one 5c coin paid out.
- disp_req  out  1  dispense request; held until ack.
- chg_req  out  1  pay one 5c coin; held until ack.
- coin_reject  out  1  one-cycle pulse: coin returned to customer.
- credit  out  CW  current credit in units.
- busy  out  1  high in DISPENSE or CHANGE.

## Operation
- States:
  - IDLE: credit = 0.
  - CREDIT: credit > 0, awaiting sel or cancel.
  - DISPENSE
  - CHANGE
- Coin acceptance (IDLE or CREDIT):
  - Valid coin with credit + value ≤ MAX_CREDIT: credit += value.
  - IDLE → CREDIT on the first accepted coin.
  - Coin that would exceed MAX_CREDIT, code 11, or any coin in DISPENSE/CHANGE: coin_reject pulses, credit unchanged.
- sel in CREDIT with credit ≥ PRICE: credit −= PRICE, go to DISPENSE.
- sel with credit < PRICE, or sel in IDLE/DISPENSE/CHANGE: ignored; no state change.
- cancel in CREDIT: go to CHANGE. cancel elsewhere is ignored.
- Priority within one cycle in CREDIT: cancel > coin > sel.
  - A coin arriving with sel is accepted; that sel is dropped.
  - cancel with a coin: the coin is rejected and the refund starts.
- DISPENSE:
  - disp_req = 1 until disp_ack is sampled high.
  - Then go to CHANGE if credit > 0, else IDLE.
- CHANGE:
  - chg_req = 1.
  - Each sampled chg_ack: credit −= 1.
  - The ack that takes credit to 0 moves to IDLE.
- Arithmetic: credit is unsigned CW bits and never wraps; saturation is enforced by rejection, not clamping.
- Acks while the matching req is low are ignored.

## Timing
- Reset values: state IDLE, credit 0, disp_req 0, chg_req 0, coin_reject 0, busy 0.
- Reset mid-operation aborts immediately; outstanding credit is discarded.
- Credit update: one cycle. credit reflects a coin on the edge after the coin cycle.
- coin_reject asserts on the edge after the offending coin cycle, for exactly one cycle.
- disp_req and busy rise on the edge after the accepted sel.
- Acks:
  - An ack sampled high with req high ends the handshake.
  - disp_req (or chg_req) is low on the next edge.
  - CHANGE starts with chg_req high on that same next edge: zero gap cycles.
- chg_req may stay continuously high across consecutive change coins.
  - Each ack-high cycle counts as one coin.
  - chg_req drops only on leaving CHANGE.
- Minimum vend, 10c+5c+sel with immediate ack: disp_req is high 1 cycle, back in IDLE 2 cycles after sel.

## Configuration
- VEND_TIMEOUT_EN defined:
  - A cycle counter runs in CREDIT and clears on any accepted coin and on entry to CREDIT.
  - When it reaches TIMEOUT_CYC, go to CHANGE and refund the full credit.
  - The counter is inactive in all other states.
- Not defined: no counter logic; CREDIT persists indefinitely.

## Structure
- Package vend_pkg holds:
  - state enum (IDLE, CREDIT, DISPENSE, CHANGE);
  - coin code constants COIN_NONE, COIN_5, COIN_10, COIN_BAD;
  - function coin_value(code) returning units.
- No sub-module needed. Optionally, split the timeout counter into vend_timeout, instantiated under VEND_TIMEOUT_EN.

## Test plan
- 5c, then 10c, then sel, disp_ack after 3 cycles → disp_req high 3 cycles, credit 0, IDLE, no chg_req.
- 10c, 10c, sel, ack → credit 4 → 1 at DISPENSE entry; one chg_req/chg_ack handshake; IDLE.
- 10c ×3 (credit 6), then 5c → coin_reject one-cycle pulse, credit stays 6; code 11 in IDLE → reject, stays IDLE.
- 10c, cancel → CHANGE, chg_ack held high 2 cycles → credit 2 → 0, IDLE; sel during CHANGE ignored.
- VEND_TIMEOUT_EN, TIMEOUT_CYC=10: 5c, then idle → CHANGE entered exactly 10 cycles after the coin; a 5c at cycle 8 restarts the count.
- Reset asserted during DISPENSE with credit 3 → next edge: disp_req 0, credit 0, IDLE; a later disp_ack is ignored.
